// File: rtl/cam_pkg.sv
// Shared types and constants for the OV5640 DVP capture path.
package cam_pkg;

  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int SLOT_W       = 2;
  localparam int PIX_CNT_W    = 11;
  localparam int SKIP_W       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2
  } cam_state_t;

  // Move k pixels held in the low slots up to the top slots, zero-filling below.
  function automatic logic [WORD_W-1:0] align_pending(input logic [WORD_W-1:0] word,
                                                      input logic [SLOT_W-1:0] k);
    return word << (PIX_W * (PIX_PER_WORD - int'(k)));
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the camera sync lines once and derives single-cycle edge pulses
// from the registered copies.
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic vs_lvl,
  output logic vs_rise,
  output logic href_lvl,
  output logic href_fall
);

  logic vs_q_reg;
  logic vs_d_reg;
  logic href_q_reg;
  logic href_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q_reg   <= 1'b0;
      vs_d_reg   <= 1'b0;
      href_q_reg <= 1'b0;
      href_d_reg <= 1'b0;
    end else begin
      vs_q_reg   <= vsync;
      vs_d_reg   <= vs_q_reg;
      href_q_reg <= href;
      href_d_reg <= href_q_reg;
    end
  end

  assign vs_lvl    = vs_q_reg;
  assign vs_rise   = vs_q_reg & ~vs_d_reg;
  assign href_lvl  = href_q_reg;
  assign href_fall = ~href_q_reg & href_d_reg;

endmodule

// File: rtl/cmos_pixel_pack.sv
// OV5640 RGB565 DVP capture: pairs bytes into pixels, packs four pixels per
// 64-bit write to the frame-buffer FIFO, skips settling frames, flags bad lines.
module cmos_pixel_pack
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int H_ACTIVE    = 640,
  parameter int SKIP_FRAMES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic [7:0]            cam_data,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  vin_vs,
  output logic [7:0]            frame_cnt,
  output logic                  line_err
);

  logic vs_lvl;
  logic vs_rise;
  logic href_lvl;
  logic href_fall;

  cam_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .vsync     (cam_vsync),
    .href      (cam_href),
    .vs_lvl    (vs_lvl),
    .vs_rise   (vs_rise),
    .href_lvl  (href_lvl),
    .href_fall (href_fall)
  );

  cam_state_t            state_reg, state_next;
  logic [SKIP_W-1:0]     skip_reg, skip_next;
  logic [7:0]            data_q_reg;
  logic [7:0]            msb_reg;
  logic                  phase_reg;
  logic [SLOT_W-1:0]     slot_reg;
  logic [WORD_W-1:0]     word_reg;
  logic [PIX_CNT_W-1:0]  pix_cnt_reg;
  logic                  wr_en_reg;
  logic [WORD_W-1:0]     wr_data_reg;
  logic                  vin_vs_reg;
  logic [7:0]            frame_cnt_reg;
  logic                  line_err_reg;

  logic              capturing;
  logic              byte_ok;
  logic              line_end;
  logic [PIX_W-1:0]  pix;
  logic [WORD_W-1:0] word_shifted;

  // While vsync is high the href line is treated as blanking.
  assign capturing    = (state_reg == CAPTURE);
  assign byte_ok      = capturing && href_lvl && !vs_lvl;
  assign line_end     = capturing && href_fall && !vs_lvl;
  assign pix          = {msb_reg, data_q_reg};
  assign word_shifted = {word_reg[WORD_W-PIX_W-1:0], pix};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      skip_reg  <= '0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    case (state_reg)
      IDLE: begin
        if (vs_rise && enable) begin
          skip_next  = '0;
          state_next = (SKIP_FRAMES == 0) ? CAPTURE : SKIP;
        end
      end
      SKIP: begin
        if (vs_rise) begin
          if (!enable) begin
            state_next = IDLE;
          end else if (skip_reg + SKIP_W'(1) == SKIP_W'(SKIP_FRAMES)) begin
            state_next = CAPTURE;
          end else begin
            skip_next = skip_reg + SKIP_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (vs_rise && !enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q_reg    <= '0;
      msb_reg       <= '0;
      phase_reg     <= 1'b0;
      slot_reg      <= '0;
      word_reg      <= '0;
      pix_cnt_reg   <= '0;
      wr_en_reg     <= 1'b0;
      wr_data_reg   <= '0;
      vin_vs_reg    <= 1'b0;
      frame_cnt_reg <= '0;
      line_err_reg  <= 1'b0;
    end else begin
      data_q_reg <= cam_data;
      wr_en_reg  <= 1'b0;
      vin_vs_reg <= capturing && vs_lvl;

      if (vs_rise) begin
        // A new frame drops whatever was in flight without flushing it.
        phase_reg   <= 1'b0;
        slot_reg    <= '0;
        word_reg    <= '0;
        pix_cnt_reg <= '0;
        if (capturing) frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end else if (line_end) begin
        if (slot_reg != '0) begin
          wr_en_reg   <= 1'b1;
          wr_data_reg <= align_pending(word_reg, slot_reg);
        end
        if (phase_reg || pix_cnt_reg != PIX_CNT_W'(H_ACTIVE)) line_err_reg <= 1'b1;
        phase_reg   <= 1'b0;
        slot_reg    <= '0;
        word_reg    <= '0;
        pix_cnt_reg <= '0;
      end else if (byte_ok) begin
        if (!phase_reg) begin
          msb_reg   <= data_q_reg;
          phase_reg <= 1'b1;
        end else begin
          phase_reg <= 1'b0;
          if (pix_cnt_reg != '1) pix_cnt_reg <= pix_cnt_reg + PIX_CNT_W'(1);
          if (slot_reg == SLOT_W'(PIX_PER_WORD - 1)) begin
            wr_en_reg   <= 1'b1;
            wr_data_reg <= word_shifted;
            word_reg    <= '0;
            slot_reg    <= '0;
          end else begin
            word_reg <= word_shifted;
            slot_reg <= slot_reg + SLOT_W'(1);
          end
        end
      end
    end
  end

  assign wr_en     = wr_en_reg;
  assign wr_data   = wr_data_reg;
  assign vin_vs    = vin_vs_reg;
  assign frame_cnt = frame_cnt_reg;
  assign line_err  = line_err_reg;

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Scoreboard bench for cmos_pixel_pack: expected words are queued as each line
// is driven and compared in order as wr_en strobes appear.
module tb_cmos_pixel_pack;

  localparam int SKIP = 2;
  localparam int HACT = 640;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        vin_vs;
  logic [7:0]  frame_cnt;
  logic        line_err;

  cmos_pixel_pack #(
    .DATA_WIDTH  (64),
    .H_ACTIVE    (HACT),
    .SKIP_FRAMES (SKIP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .vin_vs    (vin_vs),
    .frame_cnt (frame_cnt),
    .line_err  (line_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          line_no  = 0;
  logic [63:0] exp_q [$];

  // Reference frame-level model: 0 idle, 1 skipping, 2 capturing.
  int          m_state    = 0;
  int          m_skip     = 0;
  logic [7:0]  m_frames   = 8'd0;
  logic        m_line_err = 1'b0;

  bit          lat_arm   = 1'b0;
  int          lat_start = 0;
  logic        wr_en_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en && wr_en_prev) check("wr_en_gap", 64'd1, 64'd0);
    if (wr_en) begin
      if (lat_arm) begin
        check("latency", 64'(cyc - lat_start), 64'd2);
        lat_arm = 1'b0;
      end
      if (exp_q.size() == 0) check("wr_en_spurious", 64'd1, 64'd0);
      else check("wr_data", wr_data, exp_q.pop_front());
    end
    wr_en_prev = wr_en;
  end

  task automatic model_vsync();
    if (m_state == 2) begin
      m_frames++;
      if (!enable) m_state = 0;
    end else if (m_state == 1) begin
      if (!enable) m_state = 0;
      else begin
        m_skip++;
        if (m_skip == SKIP) m_state = 2;
      end
    end else if (enable) begin
      m_skip  = 0;
      m_state = 1;
    end
  endtask

  task automatic vsync_pulse();
    int prev;
    prev = m_state;
    model_vsync();
    @(negedge clk); cam_vsync = 1'b1;
    @(negedge clk);
    check("vin_vs_early", 64'(vin_vs), 64'd0);
    @(negedge clk);
    check("vin_vs", 64'(vin_vs), 64'(prev == 2));
    repeat (2) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    check("vin_vs_low", 64'(vin_vs), 64'd0);
  endtask

  task automatic send_line(input int nbytes, input bit fixed_head);
    logic [7:0]  b [$];
    logic [7:0]  head [8];
    logic [63:0] acc;
    int          k;
    int          pushed;
    head = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    for (int i = 0; i < nbytes; i++)
      b.push_back((fixed_head && i < 8) ? head[i] : 8'($urandom));
    acc = '0; k = 0; pushed = 0;
    if (m_state == 2) begin
      for (int p = 0; p < nbytes / 2; p++) begin
        acc = {acc[47:0], b[2*p], b[2*p+1]};
        k++;
        if (k == 4) begin
          exp_q.push_back(acc);
          pushed++;
          acc = '0; k = 0;
        end
      end
      if (k != 0) begin
        exp_q.push_back(acc << (16 * (4 - k)));
        pushed++;
      end
      if ((nbytes / 2) != HACT || (nbytes % 2) != 0) m_line_err = 1'b1;
    end
    $display("line %0d: %0d bytes, %0d words expected", line_no, nbytes, pushed);
    line_no++;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = b[i];
      if (fixed_head && i == 7) begin
        lat_start = cyc;
        lat_arm   = 1'b1;
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (6) @(negedge clk);
    check("line_err", 64'(line_err), 64'(m_line_err));
  endtask

  // Drive a few bytes of a line without expecting any output from them.
  task automatic partial_bytes(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'($urandom);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_vin_vs", 64'(vin_vs), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_line_err", 64'(line_err), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Skip frames then normal capture of 640x2 frames.
    for (int f = 0; f < 12; f++) begin
      vsync_pulse();
      send_line(2 * HACT, 1'b0);
      send_line(2 * HACT, 1'b0);
    end
    vsync_pulse();

    // Known byte sequence and write latency.
    send_line(2 * HACT, 1'b1);
    vsync_pulse();

    // Long line: flush of two pending pixels, line_err sets.
    send_line(2 * (HACT + 2), 1'b0);
    // Odd byte count: last byte dropped, exactly 160 words.
    send_line(2 * HACT + 1, 1'b0);

    // vsync arrives with 3 pixels pending: no flush, fresh next line.
    partial_bytes(6);
    model_vsync();
    @(negedge clk); cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_href = 1'b0;
    repeat (2) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
    check("frame_cnt_t5", 64'(frame_cnt), 64'(m_frames));
    send_line(2 * HACT, 1'b0);

    // Reset mid-line while capturing.
    partial_bytes(6);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wr_en", 64'(wr_en), 64'd0);
    check("rst_mid_vin_vs", 64'(vin_vs), 64'd0);
    check("rst_mid_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_mid_line_err", 64'(line_err), 64'd0);
    rst = 1'b0;
    cam_href = 1'b0;
    m_state = 0; m_skip = 0; m_frames = 8'd0; m_line_err = 1'b0;
    repeat (4) @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      vsync_pulse();
      send_line(2 * HACT, 1'b0);
    end
    vsync_pulse();

    repeat (10) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
